// File: rtl/result_conv_scheduler_pkg.sv
// rtl/result_conv_scheduler_pkg.sv - shared types and constants for the result converter scheduler
package result_conv_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [7:0] MAX_DEC   = 8'd99;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

endpackage

// File: rtl/result_conv_scheduler_scan_driver.sv
// rtl/result_conv_scheduler_scan_driver.sv - 2-digit multiplexed display scanner
module result_conv_scheduler_scan_driver
  import result_conv_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       ov,
  input  logic [3:0] dig_tens,
  input  logic [3:0] dig_units,
  output logic [1:0] an,
  output logic [3:0] seg_bcd
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          slot_tens;

  // Free-running divider; keeps scanning even with nothing to show.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      slot_tens <= 1'b0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt       <= '0;
      slot_tens <= ~slot_tens;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    seg_bcd = slot_tens ? dig_tens : dig_units;
    an      = AN_OFF;
    if (valid) begin
      if (!slot_tens)
        an = AN_UNITS;
      else if (BLANK_LZ && (dig_tens == 4'd0) && !ov)
        an = AN_OFF;
      else
        an = AN_TENS;
    end
  end

endmodule

// File: rtl/result_conv_scheduler.sv
// rtl/result_conv_scheduler.sv - round-robin sequencer for the shared binary-to-BCD converter
module result_conv_scheduler
  import result_conv_scheduler_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LZ      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] val0,
  input  logic       req1,
  input  logic [7:0] val1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] conv_b,
  input  logic [3:0] conv_d,
  input  logic [3:0] conv_u,
  input  logic       conv_ov,
  output logic       busy,
  output logic       valid,
  output logic       src,
  output logic [3:0] dig_tens,
  output logic [3:0] dig_units,
  output logic       ov,
  output logic [1:0] an,
  output logic [3:0] seg_bcd
);

  state_t     state;
  logic [3:0] settle;
  logic       gnt;
  logic       last_grant;
  logic       win;
  logic       ov_next;

  // On a tie the requester that did not win last time gets the converter.
  always_comb begin
    win     = (req0 && req1) ? ~last_grant : req1;
    ov_next = conv_ov | (conv_b > MAX_DEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      conv_b     <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      src        <= 1'b0;
      dig_tens   <= '0;
      dig_units  <= '0;
      ov         <= 1'b0;
      settle     <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            conv_b     <= win ? val1 : val0;
            gnt        <= win;
            last_grant <= win;
            ack0       <= ~win;
            ack1       <= win;
            settle     <= 4'(SETTLE_CYCLES - 1);
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          if (settle != 4'd0) begin
            settle <= settle - 1'b1;
          end else begin
            // Out-of-range values discard the converter digits entirely.
            dig_tens  <= ov_next ? BCD_BLANK : conv_d;
            dig_units <= ov_next ? BCD_BLANK : conv_u;
            ov        <= ov_next;
            valid     <= 1'b1;
            src       <= gnt;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  result_conv_scheduler_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .ov        (ov),
    .dig_tens  (dig_tens),
    .dig_units (dig_units),
    .an        (an),
    .seg_bcd   (seg_bcd)
  );

endmodule

// File: tb/tb_result_conv_scheduler.sv
// tb/tb_result_conv_scheduler.sv - two configurations checked against a timeline model of the scheduler
module tb_result_conv_scheduler;

  localparam int D = 4;

  int vectors = 0;
  int miscompares = 0;
  bit done_flags [2];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int inst, input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL i%0d %s: got %0d, expected %0d", inst, nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int S    = (gi == 0) ? 1 : 3;
    localparam bit BL   = (gi == 0);
    localparam int AN_T = BL ? 3 : 1;

    logic       rst, req0, req1, ack0, ack1, conv_ov, busy, valid, src, ov, force_ov;
    logic [7:0] val0, val1, conv_b;
    logic [3:0] conv_d, conv_u, dig_tens, dig_units, seg_bcd;
    logic [1:0] an;

    result_conv_scheduler #(
      .SETTLE_CYCLES (S),
      .SCAN_DIV      (D),
      .BLANK_LZ      (BL)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .val0      (val0),
      .req1      (req1),
      .val1      (val1),
      .ack0      (ack0),
      .ack1      (ack1),
      .conv_b    (conv_b),
      .conv_d    (conv_d),
      .conv_u    (conv_u),
      .conv_ov   (conv_ov),
      .busy      (busy),
      .valid     (valid),
      .src       (src),
      .dig_tens  (dig_tens),
      .dig_units (dig_units),
      .ov        (ov),
      .an        (an),
      .seg_bcd   (seg_bcd)
    );

    // Converter stand-in: plain decimal digits, overflow only when forced.
    assign conv_d  = 4'((conv_b / 8'd10) % 8'd10);
    assign conv_u  = 4'(conv_b % 8'd10);
    assign conv_ov = force_ov;

    // Timeline model: a grant in cycle t owns the converter until t+S.
    int         cyc = 0;
    int         gnt_cyc = -100, cap_cyc = -100, free_at = 0, scan_base = 0;
    bit         armed = 1'b0, last = 1'b1, gw = 1'b0;
    logic [7:0] eb = 8'd0;
    bit         e_valid = 1'b0, e_src = 1'b0, e_ov = 1'b0;
    int         e_t = 0, e_u = 0;

    always @(posedge clk) begin
      if (rst) begin
        armed = 1'b1;
        gnt_cyc = -100; cap_cyc = -100; free_at = cyc + 1; scan_base = cyc + 1;
        last = 1'b1; gw = 1'b0; eb = 8'd0;
        e_valid = 1'b0; e_src = 1'b0; e_ov = 1'b0; e_t = 0; e_u = 0;
      end else if (armed) begin
        if (cap_cyc == cyc) begin
          e_ov    = force_ov || (eb > 99);
          e_t     = e_ov ? 15 : int'(eb) / 10;
          e_u     = e_ov ? 15 : int'(eb) % 10;
          e_valid = 1'b1;
          e_src   = gw;
        end
        if (cyc >= free_at && (req0 || req1)) begin
          gw      = (req0 && req1) ? !last : req1;
          eb      = gw ? val1 : val0;
          last    = gw;
          gnt_cyc = cyc;
          cap_cyc = cyc + S;
          free_at = cyc + S + 1;
        end
      end
      cyc++;
    end

    always @(negedge clk) begin
      if (armed) begin
        int slot, ea;
        slot = ((cyc - scan_base) / D) % 2;
        ea = !e_valid ? 3 : (slot == 0) ? 2 : (BL && e_t == 0 && !e_ov) ? 3 : 1;
        check(gi, "ack0", int'(ack0), int'(cyc == gnt_cyc + 1 && !gw));
        check(gi, "ack1", int'(ack1), int'(cyc == gnt_cyc + 1 && gw));
        check(gi, "busy", int'(busy), int'(cyc >= gnt_cyc + 1 && cyc <= gnt_cyc + S));
        check(gi, "conv_b", int'(conv_b), int'(eb));
        check(gi, "valid", int'(valid), int'(e_valid));
        check(gi, "src", int'(src), int'(e_src));
        check(gi, "ov", int'(ov), int'(e_ov));
        check(gi, "dig_tens", int'(dig_tens), e_t);
        check(gi, "dig_units", int'(dig_units), e_u);
        check(gi, "an", int'(an), ea);
        check(gi, "seg_bcd", int'(seg_bcd), (slot == 0) ? e_u : e_t);
      end
    end

    initial begin
      int n, cu, ct, rc;
      logic a0p, a1p;
      rst = 1'b1; req0 = 1'b1; val0 = 8'd57; req1 = 1'b0; val1 = 8'd0; force_ov = 1'b0;

      // Reset held two cycles with req0 already up
      @(posedge clk); #1;
      @(negedge clk);
      check(gi, "rst an", int'(an), 3);
      check(gi, "rst valid", int'(valid), 0);
      check(gi, "rst ack0", int'(ack0), 0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check(gi, "first ack0", int'(ack0), 1);
      check(gi, "first conv_b", int'(conv_b), 57);
      check(gi, "first busy", int'(busy), 1);
      @(posedge clk); #1; req0 = 1'b0;
      repeat (S - 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check(gi, "57 tens", int'(dig_tens), 5);
      check(gi, "57 units", int'(dig_units), 7);
      check(gi, "57 ov", int'(ov), 0);
      check(gi, "57 src", int'(src), 0);
      check(gi, "57 valid", int'(valid), 1);

      // Fairness from reset: both held, req0 wins the first tie
      @(posedge clk); #1; rst = 1'b1; req0 = 1'b1; val0 = 8'd12; req1 = 1'b1; val1 = 8'd34;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check(gi, "fair ack0", int'(ack0), 1);
      check(gi, "fair no ack1", int'(ack1), 0);
      @(posedge clk); #1; req0 = 1'b0;
      n = 0; @(negedge clk);
      while (!ack1 && n < 20) begin @(negedge clk); n++; end
      check(gi, "fair ack1", int'(ack1), 1);
      check(gi, "fair 12 tens", int'(dig_tens), 1);
      check(gi, "fair 12 units", int'(dig_units), 2);
      check(gi, "fair 12 src", int'(src), 0);
      @(posedge clk); #1; req1 = 1'b0;
      repeat (S - 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check(gi, "fair 34 tens", int'(dig_tens), 3);
      check(gi, "fair 34 units", int'(dig_units), 4);
      check(gi, "fair 34 src", int'(src), 1);
      @(posedge clk); #1; req0 = 1'b1; req1 = 1'b1;
      n = 0; @(negedge clk);
      while (!(ack0 || ack1) && n < 20) begin @(negedge clk); n++; end
      check(gi, "rerequest ack0", int'(ack0), 1);
      check(gi, "rerequest ack1", int'(ack1), 0);
      @(posedge clk); #1; req0 = 1'b0;
      n = 0; @(negedge clk);
      while (!ack1 && n < 20) begin @(negedge clk); n++; end
      check(gi, "rerequest ack1 later", int'(ack1), 1);
      @(posedge clk); #1; req1 = 1'b0;
      repeat (S + 1) begin @(posedge clk); #1; end

      // Out of range and the 99 boundary
      req1 = 1'b1; val1 = 8'd150;
      n = 0; @(negedge clk);
      while (!ack1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1; req1 = 1'b0;
      repeat (S - 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check(gi, "150 ov", int'(ov), 1);
      check(gi, "150 tens", int'(dig_tens), 15);
      check(gi, "150 units", int'(dig_units), 15);
      check(gi, "150 seg", int'(seg_bcd), 15);
      check(gi, "150 digit on", int'(an != 2'b11), 1);
      @(posedge clk); #1; req1 = 1'b1; val1 = 8'd99;
      n = 0; @(negedge clk);
      while (!ack1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1; req1 = 1'b0;
      repeat (S - 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check(gi, "99 ov", int'(ov), 0);
      check(gi, "99 tens", int'(dig_tens), 9);
      check(gi, "99 units", int'(dig_units), 9);

      // Scan of a single-digit result
      @(posedge clk); #1; req0 = 1'b1; val0 = 8'd7;
      n = 0; @(negedge clk);
      while (!ack0 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1; req0 = 1'b0;
      repeat (S - 1) begin @(posedge clk); #1; end
      cu = 0; ct = 0;
      for (int i = 0; i < 2 * D; i++) begin
        @(negedge clk);
        if (an == 2'b10) begin
          cu++;
          check(gi, "scan units seg", int'(seg_bcd), 7);
        end
        if (int'(an) == AN_T) ct++;
      end
      check(gi, "scan units slots", cu, D);
      check(gi, "scan tens slots", ct, D);

      // Reset during conversion
      @(posedge clk); #1; req0 = 1'b1; val0 = 8'd42;
      rc = (S >= 2) ? 2 : 1;
      repeat (rc) begin @(posedge clk); #1; end
      rst = 1'b1; req0 = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check(gi, "midrst busy", int'(busy), 0);
      check(gi, "midrst valid", int'(valid), 0);
      check(gi, "midrst tens", int'(dig_tens), 0);
      check(gi, "midrst units", int'(dig_units), 0);
      check(gi, "midrst an", int'(an), 3);
      n = 0;
      for (int i = 0; i < 3 * S + 4; i++) begin
        @(negedge clk);
        if (ack0 || ack1) n++;
      end
      check(gi, "midrst no second ack", n, 0);

      // Randomized traffic with occasional resets and forced overflow
      a0p = 1'b0; a1p = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(posedge clk); #1;
        rst = ($urandom_range(0, 99) == 0);
        if (a0p) req0 = ($urandom_range(0, 3) == 0);
        else if (!req0) begin
          req0 = ($urandom_range(0, 2) == 0);
          val0 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 99)) : 8'($urandom_range(0, 255));
        end
        if (a1p) req1 = ($urandom_range(0, 3) == 0);
        else if (!req1) begin
          req1 = ($urandom_range(0, 2) == 0);
          val1 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 99)) : 8'($urandom_range(0, 255));
        end
        force_ov = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        a0p = ack0; a1p = ack1;
      end
      @(posedge clk); #1; rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (S + 4) @(posedge clk);
      done_flags[gi] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && !(done_flags[0] && done_flags[1]); t++) @(posedge clk);
    check(-1, "completion", int'(done_flags[0] && done_flags[1]), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
